// File: rtl/coefficient_loader.sv
// Steps coefficient_num through a new coefficient set, strobing load_coeff per index.
// Optional WAIT_FREE timeout with sticky load_err: define COEFF_LOAD_TIMEOUT_EN.
module coefficient_loader #(
   parameter int NUM_COEFF     = 4,
   parameter int IDX_W         = 2,
   parameter int SETTLE_CYCLES = 1
`ifdef COEFF_LOAD_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 255
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             new_coefficient_set,
   input  logic             modwait,
   output logic [IDX_W-1:0] coefficient_num,
   output logic             load_coeff,
   output logic             clear_new_coefficient,
`ifdef COEFF_LOAD_TIMEOUT_EN
   output logic             load_err,
`endif
   output logic             loader_busy
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] WAIT_FREE = 3'd1;
   localparam logic [2:0] LOAD      = 3'd2;
   localparam logic [2:0] SETTLE    = 3'd3;
   localparam logic [2:0] CLEAR     = 3'd4;
   localparam logic [2:0] DONE      = 3'd5;

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_COEFF - 1);

   logic [2:0]       state, state_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic [SW-1:0]    scnt, scnt_n;

`ifdef COEFF_LOAD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tcnt, tcnt_n;
   logic          err, err_n;
   logic          timeout;

   assign timeout = (state == WAIT_FREE) && modwait && (tcnt == TO_LAST);
`endif

   always_comb begin
      state_n = state;
      idx_n   = idx;
      scnt_n  = scnt;
      case (state)
         IDLE: begin
            if (new_coefficient_set) begin
               state_n = WAIT_FREE;
               idx_n   = '0;
            end
         end
         WAIT_FREE: begin
            if (!modwait) begin
               state_n = LOAD;
            end
`ifdef COEFF_LOAD_TIMEOUT_EN
            else if (timeout) begin
               state_n = CLEAR;
            end
`endif
         end
         LOAD: begin
            state_n = SETTLE;
            scnt_n  = '0;
         end
         SETTLE: begin
            if (scnt == SETTLE_LAST) begin
               if (idx == IDX_LAST) begin
                  state_n = CLEAR;
               end else begin
                  idx_n   = idx + 1'b1;
                  state_n = WAIT_FREE;
               end
            end else begin
               scnt_n = scnt + 1'b1;
            end
         end
         CLEAR: begin
            state_n = DONE;
         end
         DONE: begin
            // hold here until the slave drops its flag, so the clear lag cannot retrigger
            if (!new_coefficient_set) begin
               state_n = IDLE;
               idx_n   = '0;
            end
         end
         default: begin
            state_n = IDLE;
            idx_n   = '0;
         end
      endcase
   end

`ifdef COEFF_LOAD_TIMEOUT_EN
   always_comb begin
      tcnt_n = '0;
      err_n  = err;
      if (state == WAIT_FREE && state_n == WAIT_FREE) begin
         tcnt_n = tcnt + 1'b1;
      end
      if (state == IDLE && new_coefficient_set) begin
         err_n = 1'b0;
      end else if (timeout) begin
         err_n = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt <= '0;
         err  <= 1'b0;
      end else begin
         tcnt <= tcnt_n;
         err  <= err_n;
      end
   end

   assign load_err = err;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         scnt  <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         scnt  <= scnt_n;
      end
   end

   assign coefficient_num       = (state == IDLE) ? '0 : idx;
   assign load_coeff            = (state == LOAD);
   assign clear_new_coefficient = (state == CLEAR);
   assign loader_busy           = (state != IDLE);

endmodule

// File: tb/tb_coefficient_loader.sv
// Scoreboard bench for coefficient_loader: expected strobes are queued with
// their cycle and index, and popped whenever the DUT raises a strobe.
module tb_coefficient_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       nset = 1'b0;
   logic       modwait = 1'b0;
   logic [1:0] cnum;
   logic       load;
   logic       clr;
   logic       busy;
`ifdef COEFF_LOAD_TIMEOUT_EN
   logic       lerr;
`endif

   typedef struct {
      int cyc;
      int clr;
      int idx;
   } ev_t;

   ev_t q[$];
   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;
   logic prev = 1'b0;

`ifdef COEFF_LOAD_TIMEOUT_EN
   coefficient_loader #(
      .NUM_COEFF(4), .IDX_W(2), .SETTLE_CYCLES(1), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst),
      .new_coefficient_set(nset), .modwait(modwait),
      .coefficient_num(cnum), .load_coeff(load),
      .clear_new_coefficient(clr), .load_err(lerr),
      .loader_busy(busy)
   );
`else
   coefficient_loader #(
      .NUM_COEFF(4), .IDX_W(2), .SETTLE_CYCLES(1)
   ) dut (
      .clk(clk), .rst(rst),
      .new_coefficient_set(nset), .modwait(modwait),
      .coefficient_num(cnum), .load_coeff(load),
      .clear_new_coefficient(clr),
      .loader_busy(busy)
   );
`endif

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input int c, input int k, input int i);
      ev_t e;
      e.cyc = c;
      e.clr = k;
      e.idx = i;
      q.push_back(e);
   endtask

   task automatic at(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start(output int c);
      @(posedge clk);
      #1;
      c    = cyc;
      nset = 1'b1;
   endtask

   task automatic seq_exp(input int c);
      for (int k = 0; k < 4; k++) push(c + 2 + 3 * k, 0, k);
      push(c + 13, 1, 3);
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (rst) begin
         prev <= 1'b0;
      end else begin
         if (load || clr) begin
            check("consec", {31'd0, prev}, 0);
            check("both", {31'd0, load && clr}, 0);
            if (q.size() == 0) begin
               check("unexp_strobe", 1, 0);
            end else begin
               e = q.pop_front();
               check(clr ? "clr_cyc" : "ld_cyc", cyc, e.cyc);
               check("kind", {31'd0, clr}, e.clr);
               check("idx", {30'd0, cnum}, e.idx);
            end
         end
         prev <= load || clr;
      end
   end

   task automatic run_basic();
      int c;
      start(c);
      seq_exp(c);
      at(c + 1);
      check("busy_run", {31'd0, busy}, 1);
      at(c + 14);
      nset = 1'b0;
      check("busy_done", {31'd0, busy}, 1);
      at(c + 15);
      check("busy_idle", {31'd0, busy}, 0);
      check("cnum_idle", {30'd0, cnum}, 0);
      check("q_empty", q.size(), 0);
   endtask

   initial begin
      int c;
      #1;
      check("rst_cnum", {30'd0, cnum}, 0);
      check("rst_load", {31'd0, load}, 0);
      check("rst_clr", {31'd0, clr}, 0);
      check("rst_busy", {31'd0, busy}, 0);
`ifdef COEFF_LOAD_TIMEOUT_EN
      check("rst_err", {31'd0, lerr}, 0);
`endif
      at(3);
      rst = 1'b0;
      at(5);

      run_basic();

      // modwait held for 5 cycles when idx 2 reaches WAIT_FREE
      start(c);
      push(c + 2, 0, 0);
      push(c + 5, 0, 1);
      push(c + 13, 0, 2);
      push(c + 16, 0, 3);
      push(c + 18, 1, 3);
      at(c + 7);
      modwait = 1'b1;
      at(c + 12);
      modwait = 1'b0;
      at(c + 19);
      nset = 1'b0;
      at(c + 20);
      check("t2_idle", {31'd0, busy}, 0);
      check("t2_q", q.size(), 0);

      // flag held through DONE: no retrigger
      start(c);
      seq_exp(c);
      for (int k = 14; k < 18; k++) begin
         at(c + k);
         check("t3_done_busy", {31'd0, busy}, 1);
      end
      at(c + 18);
      nset = 1'b0;
      at(c + 19);
      check("t3_idle", {31'd0, busy}, 0);
      check("t3_q", q.size(), 0);
      run_basic();

      // reset right after the idx 1 load
      start(c);
      push(c + 2, 0, 0);
      push(c + 5, 0, 1);
      at(c + 6);
      rst = 1'b1;
      #1;
      check("t4_cnum", {30'd0, cnum}, 0);
      check("t4_load", {31'd0, load}, 0);
      check("t4_clr", {31'd0, clr}, 0);
      check("t4_busy", {31'd0, busy}, 0);
      check("t4_q", q.size(), 0);
      at(c + 7);
      rst = 1'b0;
      c = cyc;
      seq_exp(c);
      at(c + 14);
      nset = 1'b0;
      at(c + 15);
      check("t4_idle", {31'd0, busy}, 0);
      check("t4_q2", q.size(), 0);

      // flag dropped after the idx 0 load
      start(c);
      seq_exp(c);
      at(c + 2);
      nset = 1'b0;
      at(c + 14);
      check("t5_done", {31'd0, busy}, 1);
      at(c + 15);
      check("t5_idle", {31'd0, busy}, 0);
      check("t5_q", q.size(), 0);

`ifdef COEFF_LOAD_TIMEOUT_EN
      start(c);
      push(c + 2, 0, 0);
      push(c + 12, 1, 1);
      at(c + 4);
      modwait = 1'b1;
      at(c + 11);
      check("t6_err_pre", {31'd0, lerr}, 0);
      at(c + 12);
      check("t6_err_set", {31'd0, lerr}, 1);
      at(c + 13);
      nset    = 1'b0;
      modwait = 1'b0;
      at(c + 14);
      check("t6_idle", {31'd0, busy}, 0);
      check("t6_err_idle", {31'd0, lerr}, 1);
      at(c + 18);
      check("t6_err_hold", {31'd0, lerr}, 1);
      check("t6_q", q.size(), 0);
      start(c);
      seq_exp(c);
      at(c + 1);
      check("t6_err_clr", {31'd0, lerr}, 0);
      at(c + 14);
      nset = 1'b0;
      at(c + 15);
      check("t6_q2", q.size(), 0);
`endif

      at(cyc + 3);
      check("final_q", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

endmodule
